step_dir_decoder: RTL and testbench
===================================

// Module: step_dir_decoder
// PURPOSE
//  Receive end of the step/dir interface driven by the motor controller: filters
//  STEP/DIR, tracks absolute position, measures step period and detects end of move.
//  Sits between the driver-side STEP/DIR pins and position/velocity readback logic.
//  Provides closed-loop checking of commanded moves (deltaPos, velocity).
// PARAMETERS
//  FILTER_LEN  4         consecutive equal samples required to accept a STEP/DIR level (1..15)
//  PERIOD_W    24        width of step-period counter/output, in clocks
//  TIMEOUT     5000000   clocks without a step before move ends (100 ms @ 50 MHz)
//  POS_W       32        width of position counter
// PORTS
//  CLK_50MHZ    in   1        system clock, 50 MHz
//  RST_N        in   1        synchronous reset, active low
//  step_in      in   1        raw STEP, asynchronous; rising edge = one step
//  dir_in       in   1        raw DIR, asynchronous; 1 = +1 per step, 0 = -1
//  clear_pos    in   1        1-cycle strobe: zero position
//  position     out  POS_W    signed absolute position, two's complement
//  step_period  out  PERIOD_W clocks between the last two accepted steps
//  period_valid out  1        1-cycle pulse when step_period updates
//  moving       out  1        1 while a move is in progress
//  move_done    out  1        1-cycle pulse at end of move
//  move_steps   out  16       steps counted in current/last move
//  dir_err      out  1        sticky protocol error flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (RST_N=0 at clock edge): all outputs 0, filters 0, period counter 0, state IDLE.
//    Reset mid-move discards the move; no move_done is issued.
//  - Input path: 2-FF synchronizer per input, then glitch filter. Filtered level changes only
//    after FILTER_LEN consecutive equal synchronized samples.
//  - Step event: rising edge of filtered STEP. Filtered DIR is sampled in the same cycle.
//  - Latency: FILTER_LEN+3 clocks from the first clock edge that samples step_in=1 to the
//    position update. Same latency to the period_valid pulse.
//  - position: +1 (dir=1) / -1 (dir=0) per step event. Wraps modulo 2^POS_W, no saturation.
//  - clear_pos in the same cycle as a step event: clear applies first, then the step,
//    so position = +1 or -1.
//  - Period counter: increments every clock and saturates at all-ones. On a step event it is
//    reset to 0. If the state is not IDLE, step_period <= counter+1 (saturated) and
//    period_valid pulses.
//  - FSM:
//    IDLE -> FIRST on step event: moving=1, move_steps=1, no period published.
//    FIRST -> RUN on step event: first period published.
//    RUN stays RUN on each step event; move_steps increments, saturating at 16'hFFFF.
//    FIRST/RUN -> IDLE when the period counter reaches TIMEOUT-1 with no step in that cycle:
//    moving=0, move_done pulses 1 cycle, move_steps holds its value until the next move.
//    A step event in the same cycle as the timeout wins: no timeout.
//  - step_period keeps its last value in IDLE.
// CONFIGURATION
//  STEP_DECODER_DIRERR_EN defined: dir_err sets (sticky, cleared only by reset) when filtered
//    DIR changes while filtered STEP is high, or within FILTER_LEN clocks before a step event.
//    The step is still counted, using DIR as sampled at the event.
//  Not defined: dir_err tied to 0 and no checking logic is synthesized.
// TESTING
//  1 Reset: RST_N=0 for 3 clocks with step_in toggling -> all outputs 0; position 0 after release.
//  2 Run: dir=1, 10 steps with period 1000 clk, high 500 -> position=10, 9 period_valid pulses
//    each with step_period=1000, moving=1, move_steps=10; position update FILTER_LEN+3=7 clk
//    after each rising edge.
//  3 Glitch: step_in high for 2 clk (FILTER_LEN=4) -> no change; high 4 clk -> position +1.
//  4 Reverse/wrap: position=0, dir=0, 1 step -> position=32'hFFFFFFFF; 2 more -> 32'hFFFFFFFD.
//  5 Timeout: 10 steps, then idle -> move_done pulses exactly TIMEOUT clk after the last step
//    event, moving=0, move_steps=10; next step -> move_steps=1, no period_valid.
//  6 clear_pos coincident with a dir=1 step event at position=57 -> position=1.
//    With STEP_DECODER_DIRERR_EN: toggle dir mid-pulse -> dir_err=1 and stays 1.

Source files
------------

// File: rtl/step_dir_decoder.sv
// step_dir_decoder: STEP/DIR receiver with glitch filtering, position, step period and move tracking.
// Define STEP_DECODER_DIRERR_EN to build the sticky DIR-vs-STEP protocol checker behind dir_err.

module sdd_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_o
);
    localparam logic [3:0] LAST_CNT = 4'(FILTER_LEN - 1);

    logic       meta_q;
    logic       sync_q;
    logic       level_q;
    logic [3:0] cnt_q;

    // Level flips only after FILTER_LEN consecutive synchronized samples disagree with it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST_CNT) begin
                level_q <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign level_o = level_q;
endmodule

module step_dir_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int PERIOD_W   = 24,
    parameter int TIMEOUT    = 5000000,
    parameter int POS_W      = 32
) (
    input  logic                CLK_50MHZ,
    input  logic                RST_N,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic                clear_pos,
    output logic [POS_W-1:0]    position,
    output logic [PERIOD_W-1:0] step_period,
    output logic                period_valid,
    output logic                moving,
    output logic                move_done,
    output logic [15:0]         move_steps,
    output logic                dir_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT - 1);

    logic                filt_step;
    logic                filt_dir;
    logic                step_prev_q;
    logic                evt_q;
    logic                evt_dir_q;
    logic [PERIOD_W-1:0] per_cnt_q;
    logic [PERIOD_W-1:0] per_inc;
    logic [POS_W-1:0]    pos_q;
    logic [POS_W-1:0]    pos_base;
    logic [POS_W-1:0]    pos_delta;
    logic [PERIOD_W-1:0] period_q;
    logic                period_valid_q;
    logic [15:0]         steps_q;
    logic                move_done_q;
    logic                move_done_d;
    logic                timeout;
    state_t              state_q;
    state_t              state_d;

    sdd_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filt (
        .clk_i   (CLK_50MHZ),
        .rst_n_i (RST_N),
        .raw_i   (step_in),
        .level_o (filt_step)
    );

    sdd_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filt (
        .clk_i   (CLK_50MHZ),
        .rst_n_i (RST_N),
        .raw_i   (dir_in),
        .level_o (filt_dir)
    );

    assign per_inc   = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
    assign timeout   = (per_cnt_q >= TO_LAST);
    // Clear is applied before the coincident step, so the result is exactly +1 or -1.
    assign pos_base  = clear_pos ? '0 : pos_q;
    assign pos_delta = evt_dir_q ? POS_W'(1) : {POS_W{1'b1}};

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        move_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt_q) state_d = FIRST;
            end
            FIRST, RUN: begin
                if (evt_q) begin
                    state_d = RUN;
                end else if (timeout) begin
                    state_d     = IDLE;
                    move_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_N) begin
            step_prev_q    <= 1'b0;
            evt_q          <= 1'b0;
            evt_dir_q      <= 1'b0;
            per_cnt_q      <= '0;
            pos_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            steps_q        <= '0;
            move_done_q    <= 1'b0;
        end else begin
            step_prev_q    <= filt_step;
            evt_q          <= filt_step & ~step_prev_q;
            evt_dir_q      <= filt_dir;
            move_done_q    <= move_done_d;
            period_valid_q <= 1'b0;

            per_cnt_q <= evt_q ? '0 : per_inc;

            if (evt_q) begin
                pos_q <= pos_base + pos_delta;
            end else if (clear_pos) begin
                pos_q <= '0;
            end

            if (evt_q && state_q != IDLE) begin
                period_q       <= per_inc;
                period_valid_q <= 1'b1;
            end

            if (evt_q) begin
                if (state_q == IDLE) begin
                    steps_q <= 16'd1;
                end else if (steps_q != 16'hFFFF) begin
                    steps_q <= steps_q + 16'd1;
                end
            end
        end
    end

`ifdef STEP_DECODER_DIRERR_EN
    localparam logic [3:0] GUARD = 4'(FILTER_LEN);

    logic       dir_prev_q;
    logic [3:0] dir_age_q;
    logic       dir_err_q;
    logic       dir_chg;

    assign dir_chg = (filt_dir != dir_prev_q);

    // dir_age_q counts clocks since the last filtered DIR change, saturating at the guard window.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_N) begin
            dir_prev_q <= 1'b0;
            dir_age_q  <= GUARD;
            dir_err_q  <= 1'b0;
        end else begin
            dir_prev_q <= filt_dir;
            if (dir_chg) begin
                dir_age_q <= '0;
            end else if (dir_age_q < GUARD) begin
                dir_age_q <= dir_age_q + 4'd1;
            end
            if ((dir_chg && filt_step) ||
                (filt_step && !step_prev_q && dir_age_q < GUARD)) begin
                dir_err_q <= 1'b1;
            end
        end
    end

    assign dir_err = dir_err_q;
`else
    assign dir_err = 1'b0;
`endif

    assign position     = pos_q;
    assign step_period  = period_q;
    assign period_valid = period_valid_q;
    assign moving       = (state_q != IDLE);
    assign move_done    = move_done_q;
    assign move_steps   = steps_q;
endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: latency, period, timeout, glitch, wrap and clear behaviour.
// TIMEOUT is shortened so move-end scenarios fit in a short run.

module tb_step_dir_decoder;
    localparam int FL  = 4;
    localparam int PW  = 24;
    localparam int TO  = 3000;
    localparam int PSW = 32;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           step_in   = 1'b0;
    logic           dir_in    = 1'b0;
    logic           clear_pos = 1'b0;
    logic [PSW-1:0] position;
    logic [PW-1:0]  step_period;
    logic           period_valid;
    logic           moving;
    logic           move_done;
    logic [15:0]    move_steps;
    logic           dir_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int md_cnt   = 0;

    logic [PSW-1:0] pos_pre;
    logic [PSW-1:0] pos_post;
    logic           pv_s;
    logic [PW-1:0]  per_s;
    int             evt_cyc;
    int             md_before;
    int             n;

    step_dir_decoder #(
        .FILTER_LEN (FL),
        .PERIOD_W   (PW),
        .TIMEOUT    (TO),
        .POS_W      (PSW)
    ) dut (
        .CLK_50MHZ    (clk),
        .RST_N        (rst_n),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .clear_pos    (clear_pos),
        .position     (position),
        .step_period  (step_period),
        .period_valid (period_valid),
        .moving       (moving),
        .move_done    (move_done),
        .move_steps   (move_steps),
        .dir_err      (dir_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (move_done) md_cnt <= md_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One step pulse; tick i=0 is the first edge that samples step_in=1, i=7 the update edge.
    task automatic do_step(input int high, input int total, input logic clr);
        for (int i = 0; i < total; i++) begin
            step_in   = (i < high);
            clear_pos = clr && (i == 7);
            tick();
            clear_pos = 1'b0;
            if (i == 6) pos_pre = position;
            if (i == 7) begin
                pos_post = position;
                pv_s     = period_valid;
                per_s    = step_period;
                evt_cyc  = cyc;
            end
        end
        step_in = 1'b0;
    endtask

    initial begin
        // Reset with step_in toggling
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_in = ~step_in;
            tick();
        end
        check_val("rst_position", position, 0);
        check_val("rst_period", step_period, 0);
        check_val("rst_pvalid", period_valid, 0);
        check_val("rst_moving", moving, 0);
        check_val("rst_done", move_done, 0);
        check_val("rst_steps", move_steps, 0);
        check_val("rst_direrr", dir_err, 0);
        step_in = 1'b0;
        rst_n   = 1'b1;
        repeat (10) tick();
        check_val("post_rst_position", position, 0);

        // Run: 10 forward steps, period 1000
        dir_in = 1'b1;
        repeat (10) tick();
        for (int k = 1; k <= 10; k++) begin
            do_step(500, 1000, 1'b0);
            check_val("run_pos_before_latency", pos_pre, k - 1);
            check_val("run_pos_at_latency", pos_post, k);
            check_val("run_pvalid", pv_s, (k > 1) ? 1 : 0);
            if (k > 1) check_val("run_period", per_s, 1000);
        end
        check_val("run_moving", moving, 1);
        check_val("run_steps", move_steps, 10);
        check_val("run_no_done", md_cnt, 0);

        // Timeout
        n = 0;
        while (!move_done && n < TO + 100) begin
            tick();
            n++;
        end
        check_val("to_done_seen", move_done, 1);
        check_val("to_delay", cyc - evt_cyc, TO);
        check_val("to_moving", moving, 0);
        check_val("to_steps_hold", move_steps, 10);
        check_val("to_period_hold", step_period, 1000);
        tick();
        check_val("to_done_pulse", move_done, 0);

        // Glitch: 2 clk high rejected, 4 clk high accepted as the first step of a new move
        step_in = 1'b1;
        tick();
        tick();
        step_in = 1'b0;
        repeat (20) tick();
        check_val("glitch_pos", position, 10);
        check_val("glitch_idle", moving, 0);
        do_step(4, 20, 1'b0);
        check_val("min_pulse_pos", pos_post, 11);
        check_val("new_move_no_pv", pv_s, 0);
        check_val("new_move_steps", move_steps, 1);
        check_val("new_move_moving", moving, 1);

        // Reverse and wrap
        clear_pos = 1'b1;
        tick();
        clear_pos = 1'b0;
        check_val("clear_pos", position, 0);
        dir_in = 1'b0;
        repeat (10) tick();
        do_step(20, 40, 1'b0);
        check_val("wrap_pos", pos_post, 32'hFFFFFFFF);
        do_step(20, 40, 1'b0);
        do_step(20, 40, 1'b0);
        check_val("wrap_pos3", pos_post, 32'hFFFFFFFD);
        check_val("rev_period", per_s, 40);

        // clear_pos coincident with a step at position 57
        clear_pos = 1'b1;
        tick();
        clear_pos = 1'b0;
        dir_in = 1'b1;
        repeat (10) tick();
        for (int k = 0; k < 57; k++) do_step(6, 16, 1'b0);
        check_val("pos_57", position, 57);
        do_step(6, 16, 1'b1);
        check_val("clear_with_step", pos_post, 1);
        check_val("clear_step_period", per_s, 16);

        // Step arriving exactly in the timeout cycle keeps the move alive
        do_step(6, TO, 1'b0);
        md_before = md_cnt;
        do_step(6, 16, 1'b0);
        check_val("race_pvalid", pv_s, 1);
        check_val("race_period", per_s, TO);
        check_val("race_no_done", md_cnt, md_before);
        check_val("race_moving", moving, 1);
        check_val("race_pos", position, 3);

        // DIR toggled while STEP is held high
        step_in = 1'b1;
        repeat (10) tick();
        dir_in = 1'b0;
        repeat (20) tick();
        step_in = 1'b0;
        repeat (20) tick();
        check_val("direrr_step_pos", position, 4);
`ifdef STEP_DECODER_DIRERR_EN
        check_val("direrr_set", dir_err, 1);
        repeat (50) tick();
        check_val("direrr_sticky", dir_err, 1);
`else
        check_val("direrr_tied", dir_err, 0);
`endif

        // Reset mid-move discards the move without move_done
        check_val("pre_rst_moving", moving, 1);
        md_before = md_cnt;
        rst_n = 1'b0;
        tick();
        tick();
        check_val("midrst_moving", moving, 0);
        check_val("midrst_pos", position, 0);
        check_val("midrst_steps", move_steps, 0);
        check_val("midrst_direrr", dir_err, 0);
        rst_n = 1'b1;
        repeat (TO + 50) tick();
        check_val("midrst_no_done", md_cnt, md_before);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
